// File: rtl/fp_pkg.sv
// Shared constants and helpers for the fp32mult datapath and its pipeline registers.
package fp_pkg;

  localparam int unsigned FP32_W = 32;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One data+valid pipeline register; load wins over clear, data only moves on load.
module pipe_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             vld_o,
  output logic             vld_d_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;

  // Next-state: capture on load, drop valid on clear, otherwise hold.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (load_i) begin
      data_d = data_i;
      vld_d  = 1'b1;
    end else if (clear_i) begin
      vld_d = 1'b0;
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign data_o  = data_q;
  assign vld_o   = vld_q;
  assign vld_d_o = vld_d;

endmodule

// File: rtl/elastic_pipereg.sv
// Elastic valid/ready register chain with bubble collapse, global stall and flush.
module elastic_pipereg
  import fp_pkg::*;
#(
  parameter int unsigned WIDTH  = FP32_W,
  parameter int unsigned STAGES = 3,
  parameter int unsigned CNT_W  = clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy
);

  logic [WIDTH-1:0]  data_q [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] clear;
  logic              move;
  logic              flush;
  logic [CNT_W-1:0]  occ_q, occ_d;

  // Advance chain from the output back, then per-stage load/clear strobes.
  always_comb begin
    adv      = '0;
    load     = '0;
    clear    = '0;
    move     = en & ~clr;
    flush    = en & clr;
    in_ready = 1'b0;

    adv[STAGES-1] = out_ready;
    for (int i = int'(STAGES) - 2; i >= 0; i--) begin
      adv[i] = ~vld_q[i+1] | adv[i+1];
    end

    in_ready = move & rst & (~vld_q[0] | adv[0]);
    load[0]  = in_valid & in_ready;
    for (int i = 1; i < int'(STAGES); i++) begin
      load[i] = move & (~vld_q[i] | adv[i]) & vld_q[i-1];
    end

    for (int i = 0; i < int'(STAGES); i++) begin
      clear[i] = flush | (move & adv[i] & ~load[i]);
    end
  end

  // Register stages; stage 0 takes the upstream payload, the rest take their predecessor.
  for (genvar g = 0; g < int'(STAGES); g++) begin : g_stage
    logic [WIDTH-1:0] stage_in;
    if (g == 0) begin : g_head
      assign stage_in = in_data;
    end else begin : g_body
      assign stage_in = data_q[g-1];
    end

    pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst),
      .load_i  (load[g]),
      .clear_i (clear[g]),
      .data_i  (stage_in),
      .data_o  (data_q[g]),
      .vld_o   (vld_q[g]),
      .vld_d_o (vld_d[g])
    );
  end

  // Occupancy tracks the popcount of the valid bits as they will be after this edge.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      occ_d = occ_d + CNT_W'(vld_d[i]);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
  assign out_data  = data_q[STAGES-1];
  assign out_valid = en & ~clr & vld_q[STAGES-1];

endmodule

// File: tb/tb_elastic_pipereg.sv
// Directed bench for elastic_pipereg (3-deep 32-bit and 1-deep 8-bit) with scoreboards.
module tb_elastic_pipereg;

  logic        clk;
  logic        rst;
  logic        en, clr;
  logic [31:0] in_data, out_data;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  occupancy;

  logic        en1, clr1;
  logic [7:0]  in_data1, out_data1;
  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [0:0]  occupancy1;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb_q [$];
  logic [7:0]  sb1_q [$];
  int pops1 = 0;
  int next1 = 0;

  elastic_pipereg #(.WIDTH(32), .STAGES(3)) u_dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  elastic_pipereg #(.WIDTH(8), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .clr(clr1),
    .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .occupancy(occupancy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: pop on transfer out (older item first), push on transfer in.
  always @(negedge clk) begin
    logic [31:0] exp_v;
    logic [7:0]  exp1;
    if (rst) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("sb_unexpected_out", out_data, 32'hxxxx_xxxx);
        else begin
          exp_v = sb_q.pop_front();
          check("sb_out", out_data, exp_v);
        end
      end
      if (in_valid && in_ready) sb_q.push_back(in_data);
      if (out_valid1 && out_ready1) begin
        pops1++;
        if (sb1_q.size() == 0) check("sb1_unexpected_out", 32'(out_data1), 32'hxxxx_xxxx);
        else begin
          exp1 = sb1_q.pop_front();
          check("sb1_out", 32'(out_data1), 32'(exp1));
        end
      end
      if (in_valid1 && in_ready1) sb1_q.push_back(in_data1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo, hi, exp_occ;
    rst = 1'b0; en = 1'b1; clr = 1'b0;
    in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b1;
    en1 = 1'b1; clr1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;

    // Reset holds everything empty even with input offered.
    repeat (2) cyc();
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_occupancy", 32'(occupancy), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_data", out_data, 0);
    cyc();
    rst = 1'b1; in_valid = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready), 1);
    cyc();

    // Streaming: four items, 3-cycle latency, one per cycle out.
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 4);
      in_data  = 32'(c + 1);
      #1;
      lo = (c - 2 > 1) ? c - 2 : 1;
      hi = (c < 4) ? c : 4;
      exp_occ = (hi >= lo) ? hi - lo + 1 : 0;
      check("stream_in_ready", 32'(in_ready), 1);
      check("stream_out_valid", 32'(out_valid), 32'((c >= 3) && (c <= 6)));
      check("stream_occupancy", 32'(occupancy), 32'(exp_occ));
      if (c >= 3 && c <= 6) check("stream_out_data", out_data, 32'(c - 2));
      cyc();
    end
    in_valid = 1'b0;

    // Backpressure: fill to full, D refused, then accepted as A leaves.
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data  = 32'hA + 32'(c);
      #1;
      check("bp_accept", 32'(in_ready), 1);
      cyc();
    end
    in_data = 32'hD;
    #1;
    check("bp_full_in_ready", 32'(in_ready), 0);
    check("bp_full_occ", 32'(occupancy), 3);
    check("bp_full_out_valid", 32'(out_valid), 1);
    check("bp_full_out_data", out_data, 32'hA);
    cyc();
    #1;
    check("bp_hold_in_ready", 32'(in_ready), 0);
    check("bp_hold_out_data", out_data, 32'hA);
    cyc();
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 1);
    check("bp_release_out_data", out_data, 32'hA);
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_drain_data", out_data, 32'hB + 32'(k));
      check("bp_drain_occ", 32'(occupancy), 32'(3 - k));
      cyc();
    end
    #1;
    check("bp_empty_occ", 32'(occupancy), 0);
    check("bp_empty_out_valid", 32'(out_valid), 0);

    // Bubble collapse: lone item runs to the end while out_ready=0.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5;
    #1;
    check("bub_accept5", 32'(in_ready), 1);
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    #1;
    check("bub_out_valid", 32'(out_valid), 1);
    check("bub_out_data", out_data, 32'h5);
    check("bub_occ1", 32'(occupancy), 1);
    in_valid = 1'b1; in_data = 32'h6;
    #1;
    check("bub_accept6", 32'(in_ready), 1);
    cyc();
    in_valid = 1'b0;
    cyc();
    #1;
    check("bub_occ2", 32'(occupancy), 2);
    check("bub_head_held", out_data, 32'h5);
    check("bub_stage0_free", 32'(in_ready), 1);
    in_valid = 1'b1; in_data = 32'h7;
    #1;
    check("bub_accept7", 32'(in_ready), 1);
    cyc();
    in_valid = 1'b0;
    #1;
    check("bub_full_occ", 32'(occupancy), 3);
    check("bub_full_in_ready", 32'(in_ready), 0);

    // Stall with clr: no effect, outputs masked for the cycle.
    en = 1'b0; clr = 1'b1;
    #1;
    check("stall_in_ready", 32'(in_ready), 0);
    check("stall_out_valid", 32'(out_valid), 0);
    cyc();
    en = 1'b1; clr = 1'b0;
    #1;
    check("stall_occ_kept", 32'(occupancy), 3);
    check("stall_out_valid_back", 32'(out_valid), 1);
    check("stall_out_data_kept", out_data, 32'h5);

    // Flush: nothing transfers during clr, chain empty afterwards, data held.
    clr = 1'b1; in_valid = 1'b1; in_data = 32'h9; out_ready = 1'b1;
    #1;
    check("flush_in_ready", 32'(in_ready), 0);
    check("flush_out_valid", 32'(out_valid), 0);
    cyc();
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sb_q.delete();
    #1;
    check("flush_occ", 32'(occupancy), 0);
    check("flush_out_valid_after", 32'(out_valid), 0);
    check("flush_data_held", out_data, 32'h5);
    check("flush_in_ready_after", 32'(in_ready), 1);

    // Reset mid-operation discards in-flight items immediately.
    in_valid = 1'b1; in_data = 32'h11;
    cyc();
    in_data = 32'h12;
    cyc();
    in_valid = 1'b0;
    #1;
    check("midrst_pre_occ", 32'(occupancy), 2);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_occ", 32'(occupancy), 0);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    sb_q.delete();
    cyc();
    rst = 1'b1;
    #1;
    check("midrst_release", 32'(in_ready), 1);
    cyc();

    // Single-stage: full with out_ready=0 refuses, full with out_ready=1 passes through.
    in_valid1 = 1'b1; in_data1 = 8'hF0; out_ready1 = 1'b0;
    cyc();
    in_data1 = 8'hF1;
    #1;
    check("s1_full_in_ready", 32'(in_ready1), 0);
    check("s1_full_out_valid", 32'(out_valid1), 1);
    check("s1_full_out_data", 32'(out_data1), 32'hF0);
    check("s1_full_occ", 32'(occupancy1), 1);
    out_ready1 = 1'b1;
    #1;
    check("s1_pass_in_ready", 32'(in_ready1), 1);
    cyc();
    in_valid1 = 1'b0;
    #1;
    check("s1_pass_out_data", 32'(out_data1), 32'hF1);
    cyc();
    #1;
    check("s1_empty_occ", 32'(occupancy1), 0);

    // Single-stage: out_ready toggling every cycle, random offers, in-order data.
    pops1 = 0;
    next1 = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready1 = (c % 2 == 0);
      in_valid1  = ($urandom_range(0, 3) != 0);
      in_data1   = 8'(next1);
      #1;
      if (in_valid1 && in_ready1) next1++;
      cyc();
    end
    in_valid1 = 1'b0; out_ready1 = 1'b1;
    for (int k = 0; k < 10 && sb1_q.size() != 0; k++) cyc();
    #1;
    check("s1_drain_empty", 32'(sb1_q.size()), 0);
    check("s1_drain_occ", 32'(occupancy1), 0);
    check("s1_count", 32'(pops1), 32'(next1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
